// File: rtl/wb_pkg.sv
// Shared Wishbone LSU definitions: width codes, FSM state encoding and alignment helper.
// The alignment helper is only called when WB_LSU_ALIGN_CHECK_EN is defined.
package wb_pkg;

  localparam logic [1:0] WB_W_BYTE = 2'b00;
  localparam logic [1:0] WB_W_HALF = 2'b01;
  localparam logic [1:0] WB_W_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CAPTURE,
    DONE
  } lsu_state_t;

  // Any width code with bit 1 set is a word access
  function automatic logic isMisaligned(input logic [1:0] width, input logic [1:0] addrLo);
    logic result;
    result = 1'b0;
    if (width[1]) begin
      result = (addrLo != 2'b00);
    end else if (width == WB_W_HALF) begin
      result = addrLo[0];
    end
    return result;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load data extension: keeps only the addressed byte/half/word and sign- or zero-extends it.
// Purely combinational so the CPU writeback path can reuse it.
module lsu_extend
  import wb_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_width,
  input  logic        i_signed,
  output logic [31:0] o_result
);

  logic w_fill;

  always_comb begin
    o_result = i_data;
    w_fill   = 1'b0;
    case (i_width)
      WB_W_BYTE: begin
        w_fill   = i_signed & i_data[7];
        o_result = {{24{w_fill}}, i_data[7:0]};
      end
      WB_W_HALF: begin
        w_fill   = i_signed & i_data[15];
        o_result = {{16{w_fill}}, i_data[15:0]};
      end
      default: begin
        o_result = i_data;
      end
    endcase
  end

endmodule

// File: rtl/wb_lsu.sv
// Load/store unit driving a single Wishbone cycle per CPU request into the byte-addressed RAM.
// Define WB_LSU_ALIGN_CHECK_EN to reject misaligned half/word requests without a bus cycle.
module wb_lsu
  import wb_pkg::*;
#(
  parameter int AW        = 8,
  parameter int TIMEOUT   = 15,
  parameter int RDATA_LAT = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [1:0]    i_width,
  input  logic          i_signed,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [31:0]   o_rdata,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [1:0]    o_wb_width,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  input  logic          i_wb_stl,
  input  logic          i_wb_ack,
  input  logic [31:0]   i_wb_data
);

  lsu_state_t r_state;
  lsu_state_t w_stateNext;

  logic          r_we;
  logic          r_signed;
  logic          r_err;
  logic [1:0]    r_width;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic [7:0]    r_timeoutCnt;

  logic [7:0]    w_timeoutCntNext;
  logic          w_errNext;
  logic          w_load;
  logic          w_capture;
  logic          w_ackTaken;
  logic          w_timeoutHit;
  logic          w_misaligned;
  logic [31:0]   w_extData;

`ifdef WB_LSU_ALIGN_CHECK_EN
  assign w_misaligned = isMisaligned(i_width, i_addr[1:0]);
`else
  assign w_misaligned = 1'b0;
`endif

  // An ack only counts once the strobe has been accepted (stall low in REQ) or while waiting
  assign w_ackTaken   = ((r_state == REQ) && !i_wb_stl && i_wb_ack) ||
                        ((r_state == WAIT) && i_wb_ack);
  assign w_timeoutHit = (r_timeoutCnt == 8'(TIMEOUT - 1));

  lsu_extend u_extend (
    .i_data   (i_wb_data),
    .i_width  (r_width),
    .i_signed (r_signed),
    .o_result (w_extData)
  );

  always_comb begin
    w_stateNext      = r_state;
    w_timeoutCntNext = r_timeoutCnt;
    w_errNext        = r_err;
    w_load           = 1'b0;
    w_capture        = 1'b0;

    case (r_state)
      IDLE: begin
        w_timeoutCntNext = 8'd0;
        if (i_req) begin
          w_load = 1'b1;
          if (w_misaligned) begin
            w_stateNext = DONE;
            w_errNext   = 1'b1;
          end else begin
            w_stateNext = REQ;
            w_errNext   = 1'b0;
          end
        end
      end
      REQ: begin
        if (!i_wb_stl && !i_wb_ack) begin
          w_stateNext      = WAIT;
          w_timeoutCntNext = 8'd0;
        end
      end
      WAIT: begin
        // A late ack in the expiry cycle still wins over the timeout
        if (!i_wb_ack) begin
          if (w_timeoutHit) begin
            w_stateNext = DONE;
            w_errNext   = 1'b1;
          end else begin
            w_timeoutCntNext = r_timeoutCnt + 8'd1;
          end
        end
      end
      CAPTURE: begin
        w_capture   = 1'b1;
        w_stateNext = DONE;
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    if (w_ackTaken) begin
      if (!r_we && (RDATA_LAT != 0)) begin
        w_stateNext = CAPTURE;
      end else begin
        w_stateNext = DONE;
        w_capture   = !r_we;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_we         <= 1'b0;
      r_signed     <= 1'b0;
      r_err        <= 1'b0;
      r_width      <= 2'b00;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_rdata      <= 32'd0;
      r_timeoutCnt <= 8'd0;
    end else begin
      r_state      <= w_stateNext;
      r_timeoutCnt <= w_timeoutCntNext;
      r_err        <= w_errNext;
      if (w_load) begin
        r_we     <= i_we;
        r_signed <= i_signed;
        r_width  <= i_width;
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
      end
      if (w_capture) begin
        r_rdata <= w_extData;
      end
    end
  end

  assign o_busy     = (r_state != IDLE);
  assign o_done     = (r_state == DONE);
  assign o_err      = (r_state == DONE) && r_err;
  assign o_rdata    = r_rdata;
  assign o_wb_cyc   = (r_state == REQ) || (r_state == WAIT);
  assign o_wb_stb   = (r_state == REQ);
  assign o_wb_we    = r_we;
  assign o_wb_width = r_width;
  assign o_wb_addr  = r_addr;
  assign o_wb_data  = r_wdata;

endmodule

// File: tb/tb_wb_lsu.sv
// Self-checking bench for wb_lsu: a byte-array memory model acts as the Wishbone slave and
// predicts load results, error flags and request-to-done latency.
module tb_wb_lsu;

  localparam int AW        = 8;
  localparam int TIMEOUT   = 15;
  localparam int RDATA_LAT = 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0;
  logic          i_we = 1'b0;
  logic [1:0]    i_width = 2'b00;
  logic          i_signed = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [31:0]   i_wdata = 32'd0;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [31:0]   o_rdata;
  logic          o_wb_cyc;
  logic          o_wb_stb;
  logic          o_wb_we;
  logic [1:0]    o_wb_width;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic          i_wb_stl = 1'b0;
  logic          i_wb_ack = 1'b0;
  logic [31:0]   i_wb_data = 32'd0;

  int total = 0;
  int bad = 0;

  logic [7:0]  mem [256];
  logic [31:0] expRdata = 32'd0;

  always #5 clk = ~clk;

  wb_lsu #(
    .AW        (AW),
    .TIMEOUT   (TIMEOUT),
    .RDATA_LAT (RDATA_LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_width    (i_width),
    .i_signed   (i_signed),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_rdata    (o_rdata),
    .o_wb_cyc   (o_wb_cyc),
    .o_wb_stb   (o_wb_stb),
    .o_wb_we    (o_wb_we),
    .o_wb_width (o_wb_width),
    .o_wb_addr  (o_wb_addr),
    .o_wb_data  (o_wb_data),
    .i_wb_stl   (i_wb_stl),
    .i_wb_ack   (i_wb_ack),
    .i_wb_data  (i_wb_data)
  );

  function automatic int widthBytes(input logic [1:0] width);
    return width[1] ? 4 : (width[0] ? 2 : 1);
  endfunction

  // Expected load result assembled byte by byte from the memory model
  function automatic logic [31:0] modelLoad(input logic [1:0] width, input logic sgn, input logic [7:0] addr);
    int n;
    logic [31:0] val;
    logic [7:0] a;
    n = widthBytes(width);
    val = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = addr + 8'(k);
      val = val | (32'(mem[a]) << (8 * k));
    end
    if (sgn && val[8 * n - 1]) begin
      for (int k = n; k < 4; k++) val = val | (32'hFF << (8 * k));
    end
    return val;
  endfunction

  // The slave always returns four bytes, so bytes beyond the access width are stale
  function automatic logic [31:0] slaveWord(input logic [7:0] addr);
    logic [31:0] w;
    logic [7:0] a;
    w = 32'd0;
    for (int k = 0; k < 4; k++) begin
      a = addr + 8'(k);
      w = w | (32'(mem[a]) << (8 * k));
    end
    return w;
  endfunction

  task automatic modelStore(input logic [1:0] width, input logic [7:0] addr, input logic [31:0] data);
    logic [7:0] a;
    for (int k = 0; k < widthBytes(width); k++) begin
      a = addr + 8'(k);
      mem[a] = 8'((data >> (8 * k)) & 32'hFF);
    end
  endtask

  function automatic bit modelMisaligned(input logic [1:0] width, input logic [7:0] addr);
`ifdef WB_LSU_ALIGN_CHECK_EN
    if (width[1]) return addr[1:0] != 2'b00;
    if (width[0]) return addr[0];
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // One complete request: drives the CPU side and plays the slave, then checks the outcome
  task automatic runTxn(input logic we, input logic [1:0] width, input logic sgn,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        input int stall, input int ackDelay, input bit neverAck,
                        input bit noise, input string tag);
    int cyc, stallLeft, waitCnt, expLat, gotLat;
    bit done, accepted, acked, pend, sawCyc, expErr, mis;
    logic [31:0] word, expLoad;
    mis = modelMisaligned(width, addr);
    expErr = mis || neverAck;
    expLoad = modelLoad(width, sgn, addr);
    if (mis) expLat = 1;
    else if (neverAck) expLat = 2 + stall + TIMEOUT;
    else expLat = 2 + stall + ackDelay + ((we == 1'b0) ? RDATA_LAT : 0);

    @(negedge clk);
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL %s idle_before_req busy=%0b done=%0b required busy=0 done=0", tag, o_busy, o_done);
    end
    i_req = 1'b1; i_we = we; i_width = width; i_signed = sgn; i_addr = addr; i_wdata = wdata;
    i_wb_stl = 1'b0; i_wb_ack = 1'b0; i_wb_data = $urandom;
    cyc = 0; done = 0; accepted = 0; acked = 0; pend = 0; sawCyc = 0;
    stallLeft = stall; waitCnt = 0; gotLat = 0; word = 32'd0;

    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (o_wb_cyc) sawCyc = 1;
      if (o_done) begin
        done = 1;
        gotLat = cyc;
        i_req = 1'b0;
      end else begin
        if (noise) begin
          i_req = 1'b1; i_we = ~we; i_width = 2'($urandom); i_addr = addr ^ 8'h5A; i_wdata = ~wdata;
        end else begin
          i_req = 1'b0;
        end
        if (o_wb_stb) begin
          total++;
          if (o_wb_addr !== addr || o_wb_data !== wdata || o_wb_we !== we || o_wb_width !== width) begin
            bad++;
            $display("[TB] FAIL %s strobe_fields addr=%h data=%h we=%0b width=%0d required addr=%h data=%h we=%0b width=%0d",
                     tag, o_wb_addr, o_wb_data, o_wb_we, o_wb_width, addr, wdata, we, width);
          end
        end
        i_wb_stl = 1'b0; i_wb_ack = 1'b0; i_wb_data = $urandom;
        if (pend) begin
          i_wb_data = word;
          pend = 0;
        end
        if (o_wb_stb && !accepted) begin
          if (stallLeft > 0) begin
            i_wb_stl = 1'b1;
            stallLeft--;
          end else begin
            accepted = 1;
            if (ackDelay == 0 && !neverAck) acked = 1;
          end
        end else if (accepted && !acked && o_wb_cyc) begin
          waitCnt++;
          if (!neverAck && waitCnt == ackDelay) acked = 1;
        end
        if (acked && !i_wb_ack && (waitCnt == ackDelay) && (o_wb_cyc) && !neverAck && accepted && (word === 32'd0 || 1'b1) && !pend && (i_wb_stl == 1'b0) && (stallLeft == 0) && (gotLat == 0)) begin
          // Issue the ack exactly once: the cycle it was decided
          if (!(o_wb_stb && waitCnt != 0)) begin
            i_wb_ack = 1'b1;
            gotLat = -1;
            word = slaveWord(addr);
            if (we) modelStore(width, addr, wdata);
            else if (RDATA_LAT == 0) i_wb_data = word;
            else pend = 1;
          end
        end
      end
    end
    i_req = 1'b0; i_wb_ack = 1'b0; i_wb_stl = 1'b0;

    total++;
    if (!done) begin
      bad++;
      $display("[TB] FAIL %s no_done_within_budget cycles=%0d required done by %0d", tag, cyc, expLat);
    end else begin
      if (!expErr && !we) expRdata = expLoad;
      total++;
      if (gotLat !== expLat) begin
        bad++;
        $display("[TB] FAIL %s latency got=%0d required=%0d", tag, gotLat, expLat);
      end
      total++;
      if (o_err !== expErr) begin
        bad++;
        $display("[TB] FAIL %s err got=%0b required=%0b", tag, o_err, expErr);
      end
      total++;
      if (o_rdata !== expRdata) begin
        bad++;
        $display("[TB] FAIL %s rdata got=%h required=%h", tag, o_rdata, expRdata);
      end
      total++;
      if (o_wb_cyc !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s cyc_at_done got=%0b required=0", tag, o_wb_cyc);
      end
      if (mis) begin
        total++;
        if (sawCyc) begin
          bad++;
          $display("[TB] FAIL %s misaligned_started_cycle cyc_seen=1 required=0", tag);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_controls got=%b required=000000", {o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we});
    end
    total++;
    if (o_rdata !== 32'd0 || o_wb_data !== 32'd0 || o_wb_addr !== '0 || o_wb_width !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_data rdata=%h data=%h addr=%h width=%0d required all zero", o_rdata, o_wb_data, o_wb_addr, o_wb_width);
    end
    reset_n = 1'b1;
    expRdata = 32'd0;
  endtask

  task automatic test_store_load_word;
    runTxn(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 0, 0, 0, 0, "word_store");
    runTxn(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 0, 0, 0, 0, "word_load");
    total++;
    if (o_rdata !== 32'hDEADBEEF) begin
      bad++;
      $display("[TB] FAIL word_load_const got=%h required=deadbeef", o_rdata);
    end
  endtask

  task automatic test_byte_sign;
    runTxn(1'b1, 2'b00, 1'b0, 8'h20, 32'h12345680, 0, 0, 0, 0, "byte_store");
    runTxn(1'b0, 2'b00, 1'b1, 8'h20, 32'h0, 0, 1, 0, 0, "byte_load_signed");
    total++;
    if (o_rdata !== 32'hFFFFFF80) begin
      bad++;
      $display("[TB] FAIL byte_signed_const got=%h required=ffffff80", o_rdata);
    end
    runTxn(1'b0, 2'b00, 1'b0, 8'h20, 32'h0, 0, 2, 0, 0, "byte_load_unsigned");
    total++;
    if (o_rdata !== 32'h00000080) begin
      bad++;
      $display("[TB] FAIL byte_unsigned_const got=%h required=00000080", o_rdata);
    end
  endtask

  task automatic test_half_stale;
    runTxn(1'b1, 2'b10, 1'b0, 8'h30, 32'hFFFFFFFF, 0, 0, 0, 0, "ones_store");
    runTxn(1'b0, 2'b10, 1'b0, 8'h30, 32'h0, 0, 0, 0, 0, "ones_load");
    runTxn(1'b1, 2'b01, 1'b0, 8'h30, 32'hAAAA8001, 0, 0, 0, 0, "half_store");
    runTxn(1'b0, 2'b01, 1'b0, 8'h30, 32'h0, 0, 0, 0, 0, "half_load");
    total++;
    if (o_rdata !== 32'h00008001) begin
      bad++;
      $display("[TB] FAIL half_stale_const got=%h required=00008001", o_rdata);
    end
  endtask

  task automatic test_stall;
    runTxn(1'b1, 2'b10, 1'b0, 8'h44, 32'hCAFEF00D, 3, 0, 0, 1, "stall_store");
    runTxn(1'b0, 2'b10, 1'b0, 8'h44, 32'h0, 3, 2, 0, 1, "stall_load");
  endtask

  task automatic test_timeout;
    runTxn(1'b0, 2'b10, 1'b0, 8'h50, 32'h0, 0, 0, 1, 0, "never_ack");
    runTxn(1'b1, 2'b00, 1'b0, 8'h51, 32'h77, 1, 0, 1, 0, "never_ack_store");
    runTxn(1'b0, 2'b00, 1'b1, 8'h51, 32'h0, 0, TIMEOUT, 0, 0, "ack_at_expiry");
  endtask

  task automatic test_reset_mid_wait;
    @(negedge clk);
    i_req = 1'b1; i_we = 1'b0; i_width = 2'b10; i_signed = 1'b0; i_addr = 8'h60;
    i_wb_stl = 1'b0; i_wb_ack = 1'b0;
    @(negedge clk);
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (o_wb_cyc !== 1'b1 || o_wb_stb !== 1'b0) begin
      bad++;
      $display("[TB] FAIL wait_phase cyc=%0b stb=%0b required cyc=1 stb=0", o_wb_cyc, o_wb_stb);
    end
    reset_n = 1'b0;
    @(negedge clk);
    total++;
    if (o_wb_cyc !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_wb_stb !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_mid_wait cyc=%0b busy=%0b done=%0b stb=%0b required all 0", o_wb_cyc, o_busy, o_done, o_wb_stb);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL after_reset_release done=%0b busy=%0b required 0", o_done, o_busy);
    end
    expRdata = 32'd0;
  endtask

  task automatic test_align;
`ifdef WB_LSU_ALIGN_CHECK_EN
    runTxn(1'b0, 2'b10, 1'b0, 8'h11, 32'h0, 0, 0, 0, 0, "misaligned_word");
    runTxn(1'b1, 2'b01, 1'b0, 8'h13, 32'h1234, 0, 0, 0, 0, "misaligned_half");
`endif
    runTxn(1'b0, 2'b01, 1'b1, 8'h12, 32'h0, 0, 1, 0, 0, "aligned_half");
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      runTxn(1'($urandom), 2'($urandom_range(0, 2)), 1'($urandom), 8'($urandom), $urandom,
             $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 9) == 0), 1'($urandom),
             "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset;
    test_store_load_word;
    test_byte_sign;
    test_half_stale;
    test_stall;
    test_timeout;
    test_reset_mid_wait;
    test_align;
    test_back_to_back;
    @(negedge clk);
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL final_idle done=%0b busy=%0b required 0", o_done, o_busy);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
